shift_scaler: RTL and testbench

SHIFT_SCALER -- requirements
Module: shift_scaler

---
 rtl/shift_scaler_pkg.sv | 16 +
 rtl/shift_scaler_if.sv | 22 ++
 rtl/dffr.sv | 17 +
 rtl/shift_scaler.sv | 111 +++++++++++
 tb/tb_shift_scaler.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/shift_scaler_pkg.sv
// rtl/shift_scaler_pkg.sv - shared defaults, accumulator sizing and saturation bounds
package shift_scaler_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TERMS   = 4;
  localparam int DEF_SHIFT_W = 4;

  localparam int SAT_POS = 2 ** (DEF_WIDTH - 1) - 1;
  localparam int SAT_NEG = -(2 ** (DEF_WIDTH - 1));

  // One extra bit for the exact |most-negative| magnitude, plus growth for the term sum
  function automatic int acc_width(input int width, input int terms);
    return width + 1 + $clog2(terms);
  endfunction

endpackage

// File: rtl/shift_scaler_if.sv
// rtl/shift_scaler_if.sv - sample in / scaled result out bundle
interface shift_scaler_if #(
  parameter int WIDTH = 16
);

  logic                    in_valid;
  logic signed [WIDTH-1:0] sample;
  logic                    out_valid;
  logic signed [WIDTH-1:0] dout;
  logic                    sat;

  modport master (
    output in_valid, sample,
    input  out_valid, dout, sat
  );

  modport slave (
    input  in_valid, sample,
    output out_valid, dout, sat
  );

endinterface

// File: rtl/dffr.sv
// rtl/dffr.sv - register with synchronous active-high reset to a parameterised value
module dffr #(
  parameter int             W   = 1,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) q <= RST;
    else   q <= d;
  end

endmodule

// File: rtl/shift_scaler.sv
// rtl/shift_scaler.sv - sum-of-power-of-2 gain on signed samples, 3-stage pipeline
module shift_scaler
  import shift_scaler_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TERMS   = DEF_TERMS,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_load,
  input  logic [TERMS*SHIFT_W-1:0]   shifts,
  input  logic [TERMS-1:0]           term_en,
  shift_scaler_if.slave              io
);

  localparam int ACC_W  = acc_width(WIDTH, TERMS);
  localparam int MAG_W  = WIDTH + 1;
  localparam int HALF   = (TERMS + 1) / 2;
  localparam int COEF_W = TERMS * SHIFT_W + TERMS;

  // Coefficient register: {shifts, term_en}; reset value is term 0 enabled at shift 0
  logic [COEF_W-1:0]        coef_d, coef_q;
  logic [TERMS*SHIFT_W-1:0] shift_q;
  logic [TERMS-1:0]         en_q;

  assign coef_d  = coef_load ? {shifts, term_en} : coef_q;
  assign shift_q = coef_q[COEF_W-1:TERMS];
  assign en_q    = coef_q[TERMS-1:0];

  dffr #(.W(COEF_W), .RST(COEF_W'(1))) u_coef (.clk(clk), .r(reset), .d(coef_d), .q(coef_q));

  // Stage 1: sign and per-term shifted magnitudes
  logic [MAG_W-1:0] sext, mag;
  logic [MAG_W-1:0] term_d [TERMS];
  logic [MAG_W-1:0] term_q [TERMS];
  logic             v1, s1;

  assign sext = {io.sample[WIDTH-1], io.sample};
  assign mag  = sext[MAG_W-1] ? (~sext + 1'b1) : sext;

  always_comb begin
    for (int i = 0; i < TERMS; i++) begin
      term_d[i] = '0;
      if (en_q[i] && (int'(shift_q[i*SHIFT_W +: SHIFT_W]) < MAG_W))
        term_d[i] = mag >> shift_q[i*SHIFT_W +: SHIFT_W];
    end
  end

  dffr #(.W(1)) u_v1 (.clk(clk), .r(reset), .d(io.in_valid),        .q(v1));
  dffr #(.W(1)) u_s1 (.clk(clk), .r(reset), .d(io.sample[WIDTH-1]), .q(s1));

  for (genvar g = 0; g < TERMS; g++) begin : g_term
    dffr #(.W(MAG_W)) u_term (.clk(clk), .r(reset), .d(term_d[g]), .q(term_q[g]));
  end

  // Stage 2: two partial sums
  logic [ACC_W-1:0] sa_d, sb_d, sa_q, sb_q;
  logic             v2, s2;

  always_comb begin
    sa_d = '0;
    sb_d = '0;
    for (int i = 0; i < HALF; i++)
      sa_d = sa_d + ACC_W'(term_q[i]);
    for (int i = HALF; i < TERMS; i++)
      sb_d = sb_d + ACC_W'(term_q[i]);
  end

  dffr #(.W(1))     u_v2 (.clk(clk), .r(reset), .d(v1),   .q(v2));
  dffr #(.W(1))     u_s2 (.clk(clk), .r(reset), .d(s1),   .q(s2));
  dffr #(.W(ACC_W)) u_sa (.clk(clk), .r(reset), .d(sa_d), .q(sa_q));
  dffr #(.W(ACC_W)) u_sb (.clk(clk), .r(reset), .d(sb_d), .q(sb_q));

  // Stage 3: reapply sign and clamp; dout/sat hold when no result is produced
  logic [ACC_W-1:0] total, lim;
  logic [WIDTH-1:0] dout_d;
  logic             sat_d;

  assign total = sa_q + sb_q;
  assign lim   = ACC_W'(1) << (WIDTH - 1);

  always_comb begin
    dout_d = io.dout;
    sat_d  = io.sat;
    if (v2) begin
      if (s2) begin
        if (total > lim) begin
          dout_d = {1'b1, {(WIDTH-1){1'b0}}};
          sat_d  = 1'b1;
        end else begin
          dout_d = WIDTH'(0) - total[WIDTH-1:0];
          sat_d  = 1'b0;
        end
      end else begin
        if (total >= lim) begin
          dout_d = {1'b0, {(WIDTH-1){1'b1}}};
          sat_d  = 1'b1;
        end else begin
          dout_d = total[WIDTH-1:0];
          sat_d  = 1'b0;
        end
      end
    end
  end

  dffr #(.W(1))     u_v3   (.clk(clk), .r(reset), .d(v2),     .q(io.out_valid));
  dffr #(.W(1))     u_sat  (.clk(clk), .r(reset), .d(sat_d),  .q(io.sat));
  dffr #(.W(WIDTH)) u_dout (.clk(clk), .r(reset), .d(dout_d), .q(io.dout));

endmodule

// File: tb/tb_shift_scaler.sv
// tb/tb_shift_scaler.sv - directed vectors with hand-computed results for shift_scaler
module tb_shift_scaler;
  import shift_scaler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_load;
  logic [15:0] shifts;
  logic [3:0]  term_en;

  int n_total = 0;
  int n_bad   = 0;

  shift_scaler_if #(.WIDTH(16)) ssi ();

  shift_scaler dut (
    .clk       (clk),
    .reset     (reset),
    .coef_load (coef_load),
    .shifts    (shifts),
    .term_en   (term_en),
    .io        (ssi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dv();
    return int'($signed(ssi.dout));
  endfunction

  // All tasks are entered just after a falling edge and return just after one
  task automatic load_coef(input logic [15:0] s, input logic [3:0] e);
    coef_load = 1'b1;
    shifts    = s;
    term_en   = e;
    @(negedge clk);
    coef_load = 1'b0;
  endtask

  task automatic run_one(input string tag, input int s, input int exp, input int exp_sat);
    ssi.in_valid = 1'b1;
    ssi.sample   = 16'(s);
    @(negedge clk);
    ssi.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, int'(ssi.out_valid), 0);
    @(negedge clk);
    chk({tag, "_ov"},   int'(ssi.out_valid), 1);
    chk({tag, "_dout"}, dv(), exp);
    chk({tag, "_sat"},  int'(ssi.sat), exp_sat);
  endtask

  initial begin
    reset        = 1'b1;
    coef_load    = 1'b0;
    shifts       = '0;
    term_en      = '0;
    ssi.in_valid = 1'b0;
    ssi.sample   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ov",   int'(ssi.out_valid), 0);
    chk("rst_dout", dv(), 0);
    chk("rst_sat",  int'(ssi.sat), 0);
    reset = 1'b0;

    run_one("unity_1234", 1234, 1234, 0);
    @(negedge clk);
    chk("hold_ov",   int'(ssi.out_valid), 0);
    chk("hold_dout", dv(), 1234);

    load_coef(16'h3210, 4'hf);
    ssi.in_valid = 1'b1;
    ssi.sample   = 16'(1000);
    @(negedge clk);
    ssi.sample   = 16'(-1000);
    @(negedge clk);
    ssi.in_valid = 1'b0;
    chk("b2b_early", int'(ssi.out_valid), 0);
    @(negedge clk);
    chk("b2b_ov0",   int'(ssi.out_valid), 1);
    chk("b2b_dout0", dv(), 1875);
    @(negedge clk);
    chk("b2b_ov1",   int'(ssi.out_valid), 1);
    chk("b2b_dout1", dv(), -1875);
    @(negedge clk);
    chk("b2b_idle",  int'(ssi.out_valid), 0);

    load_coef(16'h0000, 4'h1);
    run_one("neg_full", -32768, SAT_NEG, 0);
    load_coef(16'h0000, 4'h3);
    run_one("pos_clamp", 32767, SAT_POS, 1);
    run_one("neg_clamp", -32768, SAT_NEG, 1);

    load_coef(16'h0001, 4'h1);
    run_one("trunc_m7", -7, -3, 0);
    load_coef(16'h000f, 4'h1);
    run_one("shift15", 100, 0, 0);
    load_coef(16'h0000, 4'h0);
    run_one("all_off", 1234, 0, 0);
    load_coef(16'h0021, 4'h3);
    run_one("trunc_m13", -13, -9, 0);

    // Coefficient load coincident with a sample: that sample still sees the old gain
    load_coef(16'h0000, 4'h1);
    coef_load    = 1'b1;
    shifts       = 16'h0010;
    term_en      = 4'h3;
    ssi.in_valid = 1'b1;
    ssi.sample   = 16'(8);
    @(negedge clk);
    coef_load    = 1'b0;
    ssi.sample   = 16'(8);
    @(negedge clk);
    ssi.in_valid = 1'b0;
    chk("coef_early", int'(ssi.out_valid), 0);
    @(negedge clk);
    chk("coef_old", dv(), 8);
    @(negedge clk);
    chk("coef_new", dv(), 12);

    // Reset one cycle after a burst, with a competing coef_load
    ssi.in_valid = 1'b1;
    ssi.sample   = 16'(100);
    @(negedge clk);
    ssi.sample   = 16'(200);
    @(negedge clk);
    ssi.sample   = 16'(300);
    @(negedge clk);
    ssi.in_valid = 1'b0;
    reset        = 1'b1;
    coef_load    = 1'b1;
    shifts       = 16'h1111;
    term_en      = 4'hf;
    @(negedge clk);
    reset        = 1'b0;
    coef_load    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("flush_ov_%0d", i),   int'(ssi.out_valid), 0);
      chk($sformatf("flush_dout_%0d", i), dv(), 0);
      @(negedge clk);
    end
    run_one("post_rst", 1234, 1234, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
